// File: rtl/encoder.sv
// Rate-1/2 convolutional encoder with runtime-selectable constraint length (K = 3/4/5/7).
// Optional symbol counter port sym_count is enabled by defining ENCODER_SYMCOUNT_EN.
module encoder #(
  parameter logic [2:0] G3_0 = 3'o7,
  parameter logic [2:0] G3_1 = 3'o5,
  parameter logic [3:0] G4_0 = 4'o15,
  parameter logic [3:0] G4_1 = 4'o17,
  parameter logic [4:0] G5_0 = 5'o23,
  parameter logic [4:0] G5_1 = 5'o35,
  parameter logic [6:0] G7_0 = 7'o171,
  parameter logic [6:0] G7_1 = 7'o133
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       in_enable,
  input  logic [1:0] constraint_sel,
  output logic       out_enable,
  output logic       encoded_out0,
  output logic       encoded_out1
`ifdef ENCODER_SYMCOUNT_EN
  ,
  output logic [15:0] sym_count
`endif
);

  typedef enum logic [1:0] {
    SEL_K3 = 2'b00,
    SEL_K4 = 2'b01,
    SEL_K5 = 2'b10,
    SEL_K7 = 2'b11
  } k_sel_e;

  logic [2:0] shift_reg3bit;
  logic [3:0] shift_reg4bit;
  logic [4:0] shift_reg5bit;
  logic [6:0] shift_reg7bit;
  k_sel_e     sel_q;
  k_sel_e     sel_now;

  logic       sel_change;
  logic [2:0] base3;
  logic [3:0] base4;
  logic [4:0] base5;
  logic [6:0] base7;
  logic [2:0] next3;
  logic [3:0] next4;
  logic [4:0] next5;
  logic [6:0] next7;
  logic       par0;
  logic       par1;

  assign sel_now    = k_sel_e'(constraint_sel);
  assign sel_change = (sel_now != sel_q);

  // A constraint change flushes history first; an accepted bit then shifts into the cleared regs.
  always_comb begin
    // NOTE: every combinational output is assigned a default up front so no path can infer a latch.
    base3 = shift_reg3bit;
    base4 = shift_reg4bit;
    base5 = shift_reg5bit;
    base7 = shift_reg7bit;
    if (sel_change) begin
      base3 = '0;
      base4 = '0;
      base5 = '0;
      base7 = '0;
    end
    next3 = base3;
    next4 = base4;
    next5 = base5;
    next7 = base7;
    if (in_enable) begin
      next3 = {data_in, base3[2:1]};
      next4 = {data_in, base4[3:1]};
      next5 = {data_in, base5[4:1]};
      next7 = {data_in, base7[6:1]};
    end
  end

  // Generator bit K-1 lines up with the newest bit at the register MSB.
  always_comb begin
    par0 = 1'b0;
    par1 = 1'b0;
    case (sel_now)
      SEL_K3: begin
        par0 = ^(next3 & G3_0);
        par1 = ^(next3 & G3_1);
      end
      SEL_K4: begin
        par0 = ^(next4 & G4_0);
        par1 = ^(next4 & G4_1);
      end
      SEL_K5: begin
        par0 = ^(next5 & G5_0);
        par1 = ^(next5 & G5_1);
      end
      SEL_K7: begin
        par0 = ^(next7 & G7_0);
        par1 = ^(next7 & G7_1);
      end
      default: begin
        par0 = 1'b0;
        par1 = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg3bit <= '0;
      shift_reg4bit <= '0;
      shift_reg5bit <= '0;
      shift_reg7bit <= '0;
      sel_q         <= SEL_K3;
      out_enable    <= 1'b0;
      encoded_out0  <= 1'b0;
      encoded_out1  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      shift_reg3bit <= next3;
      shift_reg4bit <= next4;
      shift_reg5bit <= next5;
      shift_reg7bit <= next7;
      sel_q         <= sel_now;
      out_enable    <= in_enable;
      if (in_enable) begin
        encoded_out0 <= par0;
        encoded_out1 <= par1;
      end
    end
  end

`ifdef ENCODER_SYMCOUNT_EN
  // Counts symbols issued since reset or the last constraint change; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count <= '0;
    end else if (sel_change) begin
      sym_count <= in_enable ? 16'd1 : 16'd0;
    end else if (in_enable) begin
      sym_count <= sym_count + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: directed cases plus randomized traffic
// checked against a bit-history reference model.
module tb_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b0;
  logic       in_enable = 1'b0;
  logic [1:0] constraint_sel = 2'b00;
  logic       out_enable;
  logic       encoded_out0;
  logic       encoded_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .in_enable      (in_enable),
    .constraint_sel (constraint_sel),
    .out_enable     (out_enable),
    .encoded_out0   (encoded_out0),
    .encoded_out1   (encoded_out1)
  );

  // Reference model: list of accepted bits since the last flush, newest first.
  int hist[$];
  int model_sel;
  int exp_oe, exp_o0, exp_o1;

  function automatic int k_of(input int sel);
    case (sel)
      0: return 3;
      1: return 4;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic int gen_of(input int sel, input int which);
    case (sel)
      0: return which ? 'o5  : 'o7;
      1: return which ? 'o17 : 'o15;
      2: return which ? 'o35 : 'o23;
      default: return which ? 'o133 : 'o171;
    endcase
  endfunction

  // Parity = XOR over taps of the bit delayed by i, tap weight is generator bit K-1-i.
  function automatic int model_parity(input int sel, input int which);
    int k, g, p, b;
    k = k_of(sel);
    g = gen_of(sel, which);
    p = 0;
    for (int i = 0; i < k; i++) begin
      b = (i < hist.size()) ? hist[i] : 0;
      if ((g >> (k - 1 - i)) % 2 == 1) p = p + b;
    end
    return p % 2;
  endfunction

  task automatic model_reset();
    hist.delete();
    model_sel = 0;
    exp_oe = 0;
    exp_o0 = 0;
    exp_o1 = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, let the edge occur, update model, compare 1 time unit later.
  task automatic step(input int en, input int d, input int sel);
    @(negedge clk);
    in_enable      = en[0];
    data_in        = d[0];
    constraint_sel = sel[1:0];
    @(posedge clk);
    #1;
    if (sel != model_sel) begin
      hist.delete();
      model_sel = sel;
    end
    if (en != 0) begin
      hist.push_front(d);
      if (hist.size() > 7) void'(hist.pop_back());
      exp_o0 = model_parity(sel, 0);
      exp_o1 = model_parity(sel, 1);
    end
    exp_oe = en;
    check("out_enable", {31'd0, out_enable}, exp_oe);
    check("encoded_out0", {31'd0, encoded_out0}, exp_o0);
    check("encoded_out1", {31'd0, encoded_out1}, exp_o1);
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " reg3"}, {29'd0, dut.shift_reg3bit}, 0);
    check({tag, " reg4"}, {28'd0, dut.shift_reg4bit}, 0);
    check({tag, " reg5"}, {27'd0, dut.shift_reg5bit}, 0);
    check({tag, " reg7"}, {25'd0, dut.shift_reg7bit}, 0);
  endtask

  // Feeds 8'b01000101 MSB first, one bit every 3 clocks, and checks each symbol against a table.
  task automatic run_pattern(input int sel, input logic [15:0] table_sym, input string tag);
    logic [7:0] pat;
    pat = 8'b01000101;
    for (int i = 0; i < 8; i++) begin
      step(1, int'(pat[7-i]), sel);
      check(tag, {30'd0, encoded_out0, encoded_out1}, {30'd0, table_sym[15-2*i -: 2]});
      step(0, 0, sel);
      step(0, 0, sel);
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_enable", {31'd0, out_enable}, 0);
    check("reset out0", {31'd0, encoded_out0}, 0);
    check("reset out1", {31'd0, encoded_out1}, 0);
    check_regs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // K=3 and K=4 reference sequences
    run_pattern(0, 16'b00_11_10_11_00_11_10_00, "k3 symbol");
    step(0, 0, 1);
    run_pattern(1, 16'b00_11_11_01_11_11_11_10, "k4 symbol");

    // Handshake: idle holds outputs, back-to-back accepts give back-to-back strobes
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, i % 2, 1);

    // Sel change with simultaneous bit
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    step(1, 1, 3);
    check("selchg reg7", {25'd0, dut.shift_reg7bit}, 32'h40);
    check("selchg symbol", {30'd0, encoded_out0, encoded_out1}, 3);

    // Async reset mid-stream, between edges
    step(1, 1, 0);
    step(1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async out_enable", {31'd0, out_enable}, 0);
    check_regs_zero("async");
    model_reset();
    @(negedge clk);
    in_enable = 1'b0;
    constraint_sel = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    run_pattern(0, 16'b00_11_10_11_00_11_10_00, "rerun k3 symbol");

    // Randomized traffic against the model
    begin
      int sel;
      sel = 0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 15) == 0) sel = $urandom_range(0, 3);
        step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1), sel);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
